// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined carry-chain adder.
//   - MAX_STAGES  : largest pipeline depth the adder accepts.
//   - slice_width : width of one carry-chain slice for a given N / STAGES.
//   The stage-register struct depends on N, so it is declared inside
//   n_bit_pipe_adder, where N is known.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int unsigned MAX_STAGES = 64;

    function automatic int unsigned slice_width(input int unsigned n,
                                                input int unsigned stages);
        return (stages == 0) ? 0 : n / stages;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
//   Combinational W-bit ripple-carry adder: one slice of the pipelined chain.
//   Ports:
//     a, b  in  [W-1:0]  slice operands
//     cin   in  1        carry into bit 0 of the slice
//     s     out [W-1:0]  slice sum
//     cout  out 1        carry out of bit W-1 of the slice
// -----------------------------------------------------------------------------
module adder_slice
    import adder_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[W];
    end

endmodule

// File: rtl/n_bit_pipe_adder.sv
// -----------------------------------------------------------------------------
// n_bit_pipe_adder
//   Pipelined N-bit carry-chain adder. The chain is cut into STAGES slices of
//   W = N/STAGES bits with a register after every slice. One operand pair is
//   accepted per cycle under valid/ready; the result appears STAGES enabled
//   cycles later. The whole pipe advances together (no bubble collapsing), so
//   in_ready depends only on out_valid/out_ready.
//
//   Optional build macro: PIPE_ADDER_OVF_EN adds the registered signed
//   overflow output ovf.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     a, b       in   [N-1:0] operands
//     cin        in   carry into bit 0
//     in_valid   in   a/b/cin valid
//     in_ready   out  operand pair accepted this cycle when in_valid
//     s          out  [N-1:0] registered (a+b+cin) mod 2^N
//     cout       out  carry out of bit N-1
//     out_valid  out  s/cout valid
//     out_ready  in   downstream accepts this cycle
//     ovf        out  signed overflow (only with PIPE_ADDER_OVF_EN)
// -----------------------------------------------------------------------------
module n_bit_pipe_adder
    import adder_pkg::*;
#(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         out_valid,
    input  logic         out_ready
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned W = slice_width(N, STAGES);

    if (N < 1 || STAGES < 1 || STAGES > N || STAGES > MAX_STAGES ||
        (N % STAGES) != 0) begin : g_bad_params
        $error("n_bit_pipe_adder: illegal N/STAGES combination");
    end

    // Stage register contents. sum bits above the slices already added and
    // a_rem/b_rem bits below the next slice are don't-care.
    typedef struct packed {
        logic         valid;
        logic         carry;
        logic [N-1:0] sum;
        logic [N-1:0] a_rem;
        logic [N-1:0] b_rem;
    } stage_t;

    stage_t       src   [STAGES];  // input side of slice k
    stage_t       stg_d [STAGES];  // next value of stage register k
    stage_t       stg_q [STAGES];  // stage register k (after slice k)
    logic [W-1:0] sl_s  [STAGES];
    logic         sl_c  [STAGES];
    logic         en;

    // Single global enable: every stage moves or every stage holds.
    assign en       = !stg_q[STAGES-1].valid || out_ready;
    assign in_ready = en;

    // Slice 0 is fed straight from the ports; slice k from stage register k-1.
    always_comb begin
        src[0] = '{valid: in_valid, carry: cin, sum: '0, a_rem: a, b_rem: b};
        for (int unsigned k = 1; k < STAGES; k++) begin
            src[k] = stg_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .W (W)
        ) u_slice (
            .a    (src[k].a_rem[k*W +: W]),
            .b    (src[k].b_rem[k*W +: W]),
            .cin  (src[k].carry),
            .s    (sl_s[k]),
            .cout (sl_c[k])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            stg_d[k]                   = src[k];
            stg_d[k].sum[k*W +: W]     = sl_s[k];
            stg_d[k].carry             = sl_c[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= '0;
            end
        end else if (en) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign s         = stg_q[STAGES-1].sum;
    assign cout      = stg_q[STAGES-1].carry;
    assign out_valid = stg_q[STAGES-1].valid;

`ifdef PIPE_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b.
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = sl_c[STAGES-1] ^ (sl_s[STAGES-1][W-1] ^
                                  src[STAGES-1].a_rem[N-1] ^
                                  src[STAGES-1].b_rem[N-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: doc/n_bit_pipe_adder.md
Name: n_bit_pipe_adder

Overview:
- Parametrised, pipelined N-bit carry-chain adder. The carry chain is split into STAGES equal slices with a register boundary after each slice.
- Accepts one operand pair per cycle under a valid/ready handshake. Delivers the sum and carry-out STAGES cycles later.
- Used in datapaths where a full-width ripple chain misses timing. The handshake lets it drop into streaming pipelines directly.

Parameters:
- N, 32, operand/sum width in bits; must be >= 1.
- STAGES, 4, number of pipeline stages, 1 <= STAGES <= N, and N % STAGES == 0. Elaboration fails otherwise.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- a  input  N  operand A
- b  input  N  operand B
- cin  input  1  carry-in to bit 0
- in_valid  input  1  a/b/cin valid
- in_ready  output  1  block can accept this cycle
- s  output  N  registered sum, (a+b+cin) mod 2^N
- cout  output  1  carry out of bit N-1
- out_valid  output  1  s/cout valid
- out_ready  input  1  downstream accepts this cycle

Behaviour:
- Slice width W = N/STAGES. Slice k covers bits [k*W +: W].
- Stage register k (k = 1..STAGES) holds:
  - valid bit;
  - carry out of slice k-1;
  - sum bits of slices 0..k-1;
  - a/b bits of slices k..STAGES-1, delayed/skewed.
- Stage 1 adds slice 0 of the inputs plus cin. Stage k+1 adds slice k of the held operands plus the carry held in stage k. The last stage register drives s, cout and out_valid directly, so there is no combinational path from input to output.
- Global advance: en = !out_valid || out_ready, and in_ready = en.
  - en = 1: every stage register loads from its predecessor. The stage-1 valid loads in_valid.
  - en = 0: all stage registers hold.
- Bubbles are not collapsed. This is intentional: fixed latency, and in_ready has no combinational dependence on in_valid.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready.
  - Output transfer occurs on out_valid && out_ready.
  - Data registers may load when their valid is 0; only valid qualifies outputs.
- Latency: exactly STAGES enabled cycles from input transfer to out_valid. Throughput is 1 per cycle while out_ready = 1.
- Ordering: strictly FIFO. No transaction is lost or duplicated under any out_ready pattern.
- While out_valid = 1 and out_ready = 0, s and cout must remain stable.
- Reset (rst_n low, asynchronous, any time, including mid-stream):
  - all valid bits clear, so out_valid = 0;
  - s = 0, cout = 0;
  - in_ready = 1 the cycle after deassertion.
  - In-flight transactions are discarded.
- Arithmetic: unsigned modulo 2^N; cout is bit N of a+b+cin. The boundary case STAGES = N (W = 1) must work, and so must STAGES = 1 (single registered adder).
- Simultaneous out transfer and in transfer in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro PIPE_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), registered alongside s. ovf = signed two's-complement overflow = carry into MSB XOR carry out of MSB. It is reset to 0 and held stable under back-pressure like s.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package adder_pkg:
  - function slice_width(N, STAGES);
  - parameterised-width packed struct typedef for a stage register (valid, carry, sum, a_rem, b_rem), expressed via localparams in the module;
  - localparam for maximum supported STAGES (64).
- One sub-module: adder_slice #(W) is a combinational W-bit carry-chain add with a, b, cin, s, cout. It is instantiated STAGES times in a generate loop.

Test Plan:
- Carry through whole word (N=8, STAGES=2): a=8'hFF, b=8'h01, cin=0, out_ready=1 -> out_valid after 2 cycles, s=8'h00, cout=1.
- Carry across slice boundary (N=8, STAGES=2): a=8'h0F, b=8'h01, cin=0 -> s=8'h10, cout=0. Then a=8'h00, b=8'h00, cin=1 -> s=8'h01.
- Streaming: 4 back-to-back transfers (1+1, 2+2, 3+3, 4+4), out_ready=1 -> s = 2, 4, 6, 8 on 4 consecutive cycles starting at latency 2; in_ready stays 1.
- Back-pressure: same stream with out_ready=0 for 3 cycles once the first result appears -> in_ready=0 and s held at 2 during the stall; after release, 2, 4, 6, 8 appear exactly once each, in order.
- Reset mid-stream: rst_n low for 1 cycle with 2 transactions in flight -> out_valid=0 and s=0 immediately (asynchronous); no stale output after release; a new 5+5 yields s=10 at latency 2.
- With PIPE_ADDER_OVF_EN (N=8):
  - 8'h7F + 8'h01 -> s=8'h80, ovf=1, cout=0;
  - 8'h80 + 8'hFF -> s=8'h7F, ovf=1, cout=1;
  - 8'hFF + 8'h01 -> ovf=0.
